// File: rtl/virq_arbiter.sv
// Fixed-priority vectored-interrupt arbiter: N requesters share one CPU virq/iack port.
// Latency: virq and virq_vector are registered 1 clock after a request is sampled in IDLE.
// Backpressure: one grant at a time; it is held until the CPU acks or the winner withdraws.
//
// Ports:
//   clk_sys, reset_n  - system clock, asynchronous active-low reset
//   bus_reset         - synchronous soft reset from the CPU RESET instruction
//   req[N]            - level interrupt requests, index 0 has the highest priority
//   vec_tab[N*VW]     - vector of requester i at [i*VW +: VW], quasi-static
//   irq_en            - CPU currently accepts interrupts
//   cpu_iack          - CPU acknowledge level, held until the vector is consumed
//   virq, virq_vector - registered request and vector presented to the CPU
//   ack[N]            - one-hot (or zero) acknowledge level back to the winner
//   busy              - arbiter is not IDLE
module virq_arbiter #(
  parameter int N  = 4,
  parameter int VW = 9
) (
  input  logic            clk_sys,
  input  logic            reset_n,
  input  logic            bus_reset,
  input  logic [N-1:0]    req,
  input  logic [N*VW-1:0] vec_tab,
  input  logic            irq_en,
  input  logic            cpu_iack,
  output logic            virq,
  output logic [VW-1:0]   virq_vector,
  output logic [N-1:0]    ack,
  output logic            busy
);

  localparam int WW = (N > 1) ? $clog2(N) : 1;
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t          state_q;
  logic [WW-1:0]   winner_q;
  logic            virq_q;
  logic [VW-1:0]   vec_q;
  logic [N-1:0]    ack_q;
  logic            busy_q;

  // Priority encoder: lowest set index wins, so scan from the top down and
  // let the last (lowest) hit overwrite.
  logic [WW-1:0]   winner_d;
  logic [VW-1:0]   vec_d;
  logic            any_d;

  always_comb begin
    winner_d = '0;
    vec_d    = '0;
    any_d    = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        winner_d = WW'(i);
        vec_d    = vec_tab[i*VW +: VW];
        any_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      winner_q <= '0;
      virq_q   <= 1'b0;
      vec_q    <= '0;
      ack_q    <= '0;
      busy_q   <= 1'b0;
    end else if (bus_reset) begin
      state_q  <= IDLE;
      winner_q <= '0;
      virq_q   <= 1'b0;
      vec_q    <= '0;
      ack_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // cpu_iack is deliberately ignored here.
          if (irq_en && any_d) begin
            winner_q <= winner_d;
            vec_q    <= vec_d;
            virq_q   <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= GRANT;
          end
        end

        GRANT: begin
          // No preemption: winner and vector stay frozen. iack takes
          // precedence over a same-cycle withdrawal; irq_en is not looked at.
          if (cpu_iack) begin
            virq_q  <= 1'b0;
            ack_q   <= ONE << winner_q;
            state_q <= ACK;
          end else if (!req[winner_q]) begin
            virq_q  <= 1'b0;
            vec_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end

        ACK: begin
          if (!cpu_iack) begin
            ack_q   <= '0;
            vec_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end

        default: begin
          state_q  <= IDLE;
          winner_q <= '0;
          virq_q   <= 1'b0;
          vec_q    <= '0;
          ack_q    <= '0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign virq        = virq_q;
  assign virq_vector = vec_q;
  assign ack         = ack_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_virq_arbiter.sv
// Directed bench for virq_arbiter: reset, grant/ack, priority without
// preemption, withdrawal, masking, async and soft reset, back-to-back grants.
module tb_virq_arbiter;

  localparam int N  = 4;
  localparam int VW = 9;

  logic            clk_sys = 1'b0;
  logic            reset_n;
  logic            bus_reset;
  logic [N-1:0]    req;
  logic [N*VW-1:0] vec_tab;
  logic            irq_en;
  logic            cpu_iack;
  logic            virq;
  logic [VW-1:0]   virq_vector;
  logic [N-1:0]    ack;
  logic            busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_sys = ~clk_sys;

  virq_arbiter #(.N(N), .VW(VW)) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .bus_reset   (bus_reset),
    .req         (req),
    .vec_tab     (vec_tab),
    .irq_en      (irq_en),
    .cpu_iack    (cpu_iack),
    .virq        (virq),
    .virq_vector (virq_vector),
    .ack         (ack),
    .busy        (busy)
  );

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks all four outputs at once.
  task automatic check_out(input string tag, input logic exp_virq, input logic [VW-1:0] exp_vec,
                           input logic [N-1:0] exp_ack, input logic exp_busy);
    check({tag, ".virq"}, 32'(virq), 32'(exp_virq));
    check({tag, ".vec"},  32'(virq_vector), 32'(exp_vec));
    check({tag, ".ack"},  32'(ack), 32'(exp_ack));
    check({tag, ".busy"}, 32'(busy), 32'(exp_busy));
  endtask

  initial begin
    reset_n   = 1'b0;
    bus_reset = 1'b0;
    req       = '0;
    irq_en    = 1'b0;
    cpu_iack  = 1'b0;
    // Requester vectors: 0=0100 (timer), 1=0060 (kbd), 2=0064 (serial), 3=0274 (kbd2)
    vec_tab   = {9'o274, 9'o064, 9'o060, 9'o100};

    #3;
    check_out("reset", 1'b0, 9'o000, 4'b0000, 1'b0);
    tick();
    reset_n = 1'b1;
    tick();
    check_out("post_reset", 1'b0, 9'o000, 4'b0000, 1'b0);

    // iack in IDLE is ignored
    cpu_iack = 1'b1;
    tick();
    check_out("iack_idle", 1'b0, 9'o000, 4'b0000, 1'b0);
    cpu_iack = 1'b0;

    // Single request
    req = 4'b0010; irq_en = 1'b1;
    tick();
    check_out("single_grant", 1'b1, 9'o060, 4'b0000, 1'b1);
    cpu_iack = 1'b1;
    tick();
    check_out("single_ack1", 1'b0, 9'o060, 4'b0010, 1'b1);
    req = 4'b0000;
    tick();
    check_out("single_ack2", 1'b0, 9'o060, 4'b0010, 1'b1);
    tick();
    check_out("single_ack3", 1'b0, 9'o060, 4'b0010, 1'b1);
    cpu_iack = 1'b0;
    tick();
    check_out("single_done", 1'b0, 9'o000, 4'b0000, 1'b0);

    // Priority, no preemption
    req = 4'b1000;
    tick();
    check_out("prio_grant3", 1'b1, 9'o274, 4'b0000, 1'b1);
    req = 4'b1001;
    tick();
    check_out("prio_nopreempt", 1'b1, 9'o274, 4'b0000, 1'b1);
    cpu_iack = 1'b1;
    tick();
    check_out("prio_ack3", 1'b0, 9'o274, 4'b1000, 1'b1);
    req = 4'b0001; cpu_iack = 1'b0;
    tick();
    check_out("prio_idle", 1'b0, 9'o000, 4'b0000, 1'b0);
    tick();
    check_out("prio_grant0", 1'b1, 9'o100, 4'b0000, 1'b1);
    cpu_iack = 1'b1;
    tick();
    check("prio_ack0", 32'(ack), 32'(4'b0001));
    req = 4'b0000; cpu_iack = 1'b0;
    tick();

    // Withdrawal before iack
    req = 4'b0100;
    tick();
    check_out("wd_grant", 1'b1, 9'o064, 4'b0000, 1'b1);
    req = 4'b0000;
    tick();
    check_out("wd_drop", 1'b0, 9'o000, 4'b0000, 1'b0);
    tick();
    check_out("wd_stay", 1'b0, 9'o000, 4'b0000, 1'b0);
    // Withdrawal coinciding with iack: iack wins
    req = 4'b0100;
    tick();
    check("wd2_grant", 32'(virq), 32'(1'b1));
    req = 4'b0000; cpu_iack = 1'b1;
    tick();
    check_out("wd2_ack", 1'b0, 9'o064, 4'b0100, 1'b1);
    cpu_iack = 1'b0;
    tick();
    check_out("wd2_done", 1'b0, 9'o000, 4'b0000, 1'b0);

    // Masking
    irq_en = 1'b0; req = 4'b1111;
    tick(); tick(); tick();
    check_out("mask_hold", 1'b0, 9'o000, 4'b0000, 1'b0);
    irq_en = 1'b1;
    tick();
    check_out("mask_release", 1'b1, 9'o100, 4'b0000, 1'b1);
    cpu_iack = 1'b1;
    tick();
    check("mask_ack", 32'(ack), 32'(4'b0001));
    req = 4'b0000; cpu_iack = 1'b0;
    tick();

    // Asynchronous reset mid-ACK
    req = 4'b0010;
    tick();
    cpu_iack = 1'b1;
    tick();
    check("arst_pre_ack", 32'(ack), 32'(4'b0010));
    #1;
    reset_n = 1'b0;
    #1;
    check_out("arst_async", 1'b0, 9'o000, 4'b0000, 1'b0);
    req = 4'b0000; cpu_iack = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    check_out("arst_after", 1'b0, 9'o000, 4'b0000, 1'b0);

    // Soft reset mid-GRANT
    req = 4'b0100;
    tick();
    check("sr_grant", 32'(virq_vector), 32'(9'o064));
    bus_reset = 1'b1;
    tick();
    check_out("sr_clear", 1'b0, 9'o000, 4'b0000, 1'b0);
    tick();
    check_out("sr_held", 1'b0, 9'o000, 4'b0000, 1'b0);
    bus_reset = 1'b0;
    tick();
    check_out("sr_regrant", 1'b1, 9'o064, 4'b0000, 1'b1);
    req = 4'b0000;
    tick();
    check("sr_wd", 32'(busy), 32'(1'b0));

    // Back-to-back
    req = 4'b0011;
    tick();
    check_out("b2b_grant0", 1'b1, 9'o100, 4'b0000, 1'b1);
    cpu_iack = 1'b1;
    tick();
    check("b2b_ack0", 32'(ack), 32'(4'b0001));
    req = 4'b0010; cpu_iack = 1'b0;
    tick();
    check_out("b2b_gap1", 1'b0, 9'o000, 4'b0000, 1'b0);
    tick();
    check_out("b2b_gap2_grant1", 1'b1, 9'o060, 4'b0000, 1'b1);
    cpu_iack = 1'b1;
    tick();
    check("b2b_ack1", 32'(ack), 32'(4'b0010));
    req = 4'b0000; cpu_iack = 1'b0;
    tick();
    check_out("b2b_done", 1'b0, 9'o000, 4'b0000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/virq_arbiter.md
Name: virq_arbiter

Overview:
- Shares the CPU's single vectored-interrupt input among N peripheral requesters, e.g. keyboard vectors 060 and 274, timer, and serial.
- Selects the highest-priority pending request and presents its 9-bit vector to the CPU.
- Sequences the CPU interrupt-acknowledge back to the winning requester as a held ack level. Requesters edge-detect this level to clear their request.
- Sits between the peripheral virq_req/virq_ack pairs and the CPU core's virq/iack interface.

Parameters:
- N, 4, number of requesters. Index 0 has the highest priority.
- VW, 9, vector width in bits. Vectors are octal PDP-11 addresses up to 0776.

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- bus_reset  in  1  synchronous active-high soft reset from the CPU RESET instruction.
- req  in  N  level interrupt requests; bit i belongs to requester i.
- vec_tab  in  N*VW  vector of requester i at bits [i*VW +: VW]; quasi-static.
- irq_en  in  1  CPU accepts interrupts (PSW priority permits).
- cpu_iack  in  1  CPU acknowledge level; held high until vector is consumed.
- virq  out  1  interrupt request to CPU.
- virq_vector  out  VW  vector of granted requester; valid while virq=1.
- ack  out  N  per-requester acknowledge, one-hot or zero.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset: reset_n=0 forces asynchronously state=IDLE, virq=0, virq_vector=0, ack=0, winner=0, busy=0.
- bus_reset=1 at a clock edge has the same effect synchronously and overrides all other inputs that cycle.
- All outputs are registered.
- Priority is fixed. The winner is the lowest index i with req[i]=1. There is no round-robin and no preemption.
- IDLE:
  - Condition: irq_en=1 and |req=1.
  - Action: latch winner index and vec_tab slice into virq_vector; set virq=1; go GRANT.
  - Latency: virq is high on the edge after the request is sampled (1 clock).
  - If irq_en=0 or req=0: stay in IDLE.
- GRANT:
  - virq=1 and virq_vector is held stable, even if a higher-priority req rises (no preemption).
  - cpu_iack=1: go ACK; ack[winner]=1 from the next edge; virq=0.
  - req[winner] drops while cpu_iack=0: withdrawal. Set virq=0 and go IDLE. The next grant re-evaluates no earlier than the following cycle.
  - req[winner] drops in the same cycle as cpu_iack=1: iack wins, enter ACK, deliver ack normally.
  - irq_en falling in GRANT is ignored; the CPU owns that race.
- ACK:
  - ack[winner] is held high while cpu_iack=1. virq_vector stays stable until IDLE.
  - cpu_iack=0: ack=0, virq_vector=0, go IDLE.
  - IDLE always lasts at least one cycle before the next GRANT. Ack pulses are therefore at least 1 cycle wide and separated by at least 2 cycles.
- A cpu_iack seen in IDLE is ignored: no ack, no state change.
- busy = (state != IDLE), registered alongside state.
- State encoding is free. Illegal states recover to IDLE.
- Requesters are responsible for dropping req on the ack rising edge. If req[winner] is still high on return to IDLE, it is granted again.

Test Plan:
- Single request: N=4, vec_tab[1]=0o060. Raise req=0010 with irq_en=1. Expect virq=1 and virq_vector=0o060 one clock later. Pulse cpu_iack high for 3 clocks. Expect ack=0010 for 3 clocks, then virq=0, ack=0, busy=0.
- Priority and no preemption: req=1000 (vector 0o274) is granted. Then raise req[0] (vector 0o100) during GRANT. virq_vector must stay 0o274 until its ack completes. The next grant must be 0o100.
- Withdrawal: req=0100 is granted, then drop req[2] before any iack. Expect virq=0 the next clock, ack never asserted, state IDLE. Then a simultaneous drop with iack rising: expect ack=0100.
- Masking: irq_en=0 with req=1111 gives virq=0 indefinitely. Raising irq_en gives virq=1 with the vector of requester 0 one clock later.
- Resets: assert reset_n=0 asynchronously mid-ACK. Outputs must be zero immediately, without waiting for a clock edge. Repeat with bus_reset mid-GRANT: outputs are zero at the next edge, and the request is re-granted only after bus_reset falls.
- Back-to-back: req=0011 held, each requester drops req on its ack. Expect grant order 0 then 1, with at least 2 cycles between ack pulses.
